bnn_dot_prod_initiator: RTL and testbench

BNN_DOT_PROD_INITIATOR -- requirements
Module: bnn_dot_prod_initiator

---
 rtl/bnn_dot_prod_initiator.sv | 193 +++++++++++++++++++
 tb/tb_bnn_dot_prod_initiator.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bnn_dot_prod_initiator.sv
// Streams activation/weight word pairs to a BNNDotProd CFU with up to MAX_OUT requests in flight,
// sums the returned xnor popcounts and presents the popcount total and signed BNN dot product.
//
// state | meaning
// IDLE  | waiting for a command
// ISSUE | accepting operand pairs and sending CFU requests
// DRAIN | every pair sent, collecting the remaining responses
// DONE  | result held on res_* until res_ready
module bnn_dot_prod_initiator #(
   parameter int CFU_REQ_DATA_W    = 32,
   parameter int CFU_RESP_DATA_W   = 32,
   parameter int CFU_FUNCTION_ID_W = 1,
   parameter int LEN_W             = 8,
   parameter int MAX_OUT           = 4
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         cmd_valid,
   output logic                         cmd_ready,
   input  logic [LEN_W-1:0]             cmd_len,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [CFU_REQ_DATA_W-1:0]    in_act,
   input  logic [CFU_REQ_DATA_W-1:0]    in_wt,
   output logic                         req_valid,
   input  logic                         req_ready,
   output logic [CFU_FUNCTION_ID_W-1:0] req_function_id,
   output logic [CFU_REQ_DATA_W-1:0]    req_data0,
   output logic [CFU_REQ_DATA_W-1:0]    req_data1,
   input  logic                         resp_valid,
   output logic                         resp_ready,
   input  logic [CFU_RESP_DATA_W-1:0]   resp_data,
   output logic                         res_valid,
   input  logic                         res_ready,
   output logic [31:0]                  res_pop,
   output logic signed [31:0]           res_dot,
   output logic                         busy
);
   localparam int OUT_W = $clog2(MAX_OUT) + 1;
   localparam int MAX_OUT_I = MAX_OUT;
   localparam logic [OUT_W:0] MAX_OUT_V = MAX_OUT_I[OUT_W:0];

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

   state_t                    state_q, state_d;
   logic [LEN_W-1:0]          len_q, len_d;
   logic [LEN_W-1:0]          issued_q, issued_d;
   logic [LEN_W-1:0]          received_q, received_d;
   logic [OUT_W-1:0]          outstanding_q, outstanding_d;
   logic [31:0]               acc_q, acc_d;
   logic                      req_valid_q, req_valid_d;
   logic [CFU_REQ_DATA_W-1:0] req_data0_q, req_data0_d;
   logic [CFU_REQ_DATA_W-1:0] req_data1_q, req_data1_d;
   logic                      res_valid_q, res_valid_d;
   logic [31:0]               res_pop_q, res_pop_d;
   logic [31:0]               res_dot_q, res_dot_d;

   logic                       cmd_hs, in_hs, req_hs, resp_hs, res_hs;
   logic [OUT_W:0]             window_used;
   logic [CFU_RESP_DATA_W-1:0] unused_resp;

   assign unused_resp = resp_data;

   // A request waiting in the output register already owns a window slot, so the
   // CFU can never hold more than MAX_OUT unanswered requests.
   assign window_used = {1'b0, outstanding_q} + {{OUT_W{1'b0}}, req_valid_q};

   assign cmd_ready  = (state_q == IDLE);
   assign in_ready   = (state_q == ISSUE) && (!req_valid_q || req_ready) &&
                       (issued_q < len_q) && (window_used < MAX_OUT_V);
   assign resp_ready = (state_q == ISSUE) || (state_q == DRAIN);
   assign busy       = (state_q != IDLE);

   assign cmd_hs  = cmd_valid && cmd_ready;
   assign in_hs   = in_valid && in_ready;
   assign req_hs  = req_valid_q && req_ready;
   assign resp_hs = resp_valid && resp_ready;
   assign res_hs  = res_valid_q && res_ready;

   assign req_valid       = req_valid_q;
   assign req_data0       = req_data0_q;
   assign req_data1       = req_data1_q;
   assign req_function_id = '0;
   assign res_valid       = res_valid_q;
   assign res_pop         = res_pop_q;
   assign res_dot         = res_dot_q;

   always_comb begin
      state_d       = state_q;
      len_d         = len_q;
      issued_d      = issued_q;
      received_d    = received_q;
      outstanding_d = outstanding_q;
      acc_d         = acc_q;
      req_valid_d   = req_valid_q;
      req_data0_d   = req_data0_q;
      req_data1_d   = req_data1_q;
      res_valid_d   = res_valid_q;
      res_pop_d     = res_pop_q;
      res_dot_d     = res_dot_q;

      if (in_hs) begin
         req_valid_d = 1'b1;
         req_data0_d = in_act;
         req_data1_d = in_wt;
         issued_d    = issued_q + LEN_W'(1);
      end else if (req_hs) begin
         req_valid_d = 1'b0;
      end

      case ({req_hs, resp_hs})
         2'b10:   outstanding_d = outstanding_q + OUT_W'(1);
         2'b01:   outstanding_d = outstanding_q - OUT_W'(1);
         default: outstanding_d = outstanding_q;
      endcase

      if (resp_hs) begin
         received_d = received_q + LEN_W'(1);
         acc_d      = acc_q + {26'd0, resp_data[5:0]};
      end

      case (state_q)
         IDLE: begin
            if (cmd_hs) begin
               len_d         = cmd_len;
               issued_d      = '0;
               received_d    = '0;
               outstanding_d = '0;
               acc_d         = '0;
               if (cmd_len != '0) begin
                  state_d = ISSUE;
               end else begin
                  state_d     = DONE;
                  res_valid_d = 1'b1;
                  res_pop_d   = '0;
                  res_dot_d   = '0;
               end
            end
         end
         ISSUE: begin
            if ((issued_q == len_q) && !req_valid_q) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (received_q == len_q) begin
               state_d     = DONE;
               res_valid_d = 1'b1;
               res_pop_d   = acc_q;
               // every word contributes matches minus mismatches = 2*pop - 32
               res_dot_d   = (acc_q << 1) - ({{(32-LEN_W){1'b0}}, len_q} << 5);
            end
         end
         DONE: begin
            if (res_hs) begin
               state_d     = IDLE;
               res_valid_d = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q       <= IDLE;
         len_q         <= '0;
         issued_q      <= '0;
         received_q    <= '0;
         outstanding_q <= '0;
         acc_q         <= '0;
         req_valid_q   <= 1'b0;
         req_data0_q   <= '0;
         req_data1_q   <= '0;
         res_valid_q   <= 1'b0;
         res_pop_q     <= '0;
         res_dot_q     <= '0;
      end else begin
         state_q       <= state_d;
         len_q         <= len_d;
         issued_q      <= issued_d;
         received_q    <= received_d;
         outstanding_q <= outstanding_d;
         acc_q         <= acc_d;
         req_valid_q   <= req_valid_d;
         req_data0_q   <= req_data0_d;
         req_data1_q   <= req_data1_d;
         res_valid_q   <= res_valid_d;
         res_pop_q     <= res_pop_d;
         res_dot_q     <= res_dot_d;
      end
   end
endmodule

// File: tb/tb_bnn_dot_prod_initiator.sv
// Bench for bnn_dot_prod_initiator: a CFU/stream environment plus a word-level model of the
// expected request sequence and popcount/dot-product result, with directed and random commands.
module tb_bnn_dot_prod_initiator;
   localparam int LEN_W   = 8;
   localparam int MAX_OUT = 4;

   logic              clock = 1'b0;
   logic              reset;
   logic              cmd_valid, cmd_ready;
   logic [LEN_W-1:0]  cmd_len;
   logic              in_valid, in_ready;
   logic [31:0]       in_act, in_wt;
   logic              req_valid, req_ready;
   logic [0:0]        req_function_id;
   logic [31:0]       req_data0, req_data1;
   logic              resp_valid, resp_ready;
   logic [31:0]       resp_data;
   logic              res_valid, res_ready;
   logic [31:0]       res_pop;
   logic signed [31:0] res_dot;
   logic              busy;

   bnn_dot_prod_initiator #(
      .CFU_REQ_DATA_W(32), .CFU_RESP_DATA_W(32), .CFU_FUNCTION_ID_W(1),
      .LEN_W(LEN_W), .MAX_OUT(MAX_OUT)
   ) dut (
      .clock(clock), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
      .in_valid(in_valid), .in_ready(in_ready), .in_act(in_act), .in_wt(in_wt),
      .req_valid(req_valid), .req_ready(req_ready), .req_function_id(req_function_id),
      .req_data0(req_data0), .req_data1(req_data1),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
      .res_valid(res_valid), .res_ready(res_ready), .res_pop(res_pop), .res_dot(res_dot),
      .busy(busy)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   logic [31:0] src_act[$], src_wt[$];
   logic [31:0] exp_act[$], exp_wt[$];
   logic [31:0] cfu_resp[$];
   int          out_cnt = 0;
   int          in_cnt = 0;
   int          res_hs_cnt = 0;
   int          start_hs = 0;
   int          res_rise_cyc = 0;
   int          cmd_cyc = 0;
   bit          req_seen = 0;
   logic [31:0] exp_pop = '0, exp_dot = '0;
   logic [31:0] last_pop = '0, last_dot = '0;

   int p_in = 100, p_req = 100, p_resp = 100, p_res = 100;
   bit hold_req = 0, hold_resp = 0, hold_res = 0;

   bit f_in = 0, f_req = 0, f_resp = 0, f_res = 0;
   bit pv_req_valid = 0, pv_req_ready = 0, pv_res_valid = 0, pv_res_ready = 0;
   logic [31:0] pv_d0 = '0, pv_d1 = '0, pv_pop = '0, pv_dot = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s: required event did not happen at t=%0t", name, $time);
   endtask

   // Monitor: sees the values the next rising edge will sample.
   initial begin
      forever begin
         @(negedge clock);
         if (reset) begin
            f_in = 0; f_req = 0; f_resp = 0; f_res = 0;
            pv_req_valid = 0; pv_req_ready = 0; pv_res_valid = 0; pv_res_ready = 0;
            continue;
         end
         f_in   = in_valid && in_ready;
         f_req  = req_valid && req_ready;
         f_resp = resp_valid && resp_ready;
         f_res  = res_valid && res_ready;

         if (pv_req_valid && !pv_req_ready) begin
            check("req_hold_valid", req_valid, 1);
            check("req_hold_d0", req_data0, pv_d0);
            check("req_hold_d1", req_data1, pv_d1);
         end
         if (pv_res_valid && !pv_res_ready) begin
            check("res_hold_valid", res_valid, 1);
            check("res_hold_pop", res_pop, pv_pop);
            check("res_hold_dot", res_dot, pv_dot);
            check("done_cmd_ready", cmd_ready, 0);
            check("done_busy", busy, 1);
         end
         if (!busy) check("idle_outputs", {in_ready, resp_ready, req_valid, res_valid}, 0);
         if (req_valid) req_seen = 1;

         if (f_in) begin
            in_cnt++;
            void'(src_act.pop_front());
            void'(src_wt.pop_front());
         end
         if (f_req) begin
            if (exp_act.size() == 0) begin
               fail("req_unexpected");
            end else begin
               logic [31:0] rnd;
               logic [5:0]  pc;
               check("req_data0", req_data0, exp_act.pop_front());
               check("req_data1", req_data1, exp_wt.pop_front());
               check("req_function_id", req_function_id, 0);
               rnd = $urandom;
               pc  = 6'($countones(~(req_data0 ^ req_data1)));
               cfu_resp.push_back({rnd[31:6], pc});
            end
            out_cnt++;
            checks++;
            if (out_cnt > MAX_OUT) begin
               errors++;
               $display("FAIL max_outstanding: got %0d outstanding, at most %0d allowed", out_cnt, MAX_OUT);
            end
         end
         if (f_resp) begin
            out_cnt--;
            void'(cfu_resp.pop_front());
         end
         if (res_valid && !pv_res_valid) res_rise_cyc = cyc;
         if (f_res) begin
            check("res_pop", res_pop, exp_pop);
            check("res_dot", res_dot, exp_dot);
            last_pop = res_pop;
            last_dot = res_dot;
            res_hs_cnt++;
         end
         pv_req_valid = req_valid; pv_req_ready = req_ready;
         pv_d0 = req_data0; pv_d1 = req_data1;
         pv_res_valid = res_valid; pv_res_ready = res_ready;
         pv_pop = res_pop; pv_dot = res_dot;
      end
   end

   // Environment: operand stream, CFU (answers one cycle after accepting) and result sink.
   initial begin
      in_valid = 0; in_act = '0; in_wt = '0;
      req_ready = 0; resp_valid = 0; resp_data = '0; res_ready = 0;
      forever begin
         @(posedge clock);
         #1;
         if (reset) begin
            in_valid = 0; req_ready = 0; resp_valid = 0; res_ready = 0;
            continue;
         end
         if (!in_valid || f_in) begin
            if (src_act.size() > 0 && $urandom_range(99) < p_in) begin
               in_valid = 1; in_act = src_act[0]; in_wt = src_wt[0];
            end else begin
               in_valid = 0;
            end
         end
         req_ready = !hold_req && ($urandom_range(99) < p_req);
         if (cfu_resp.size() == 0) begin
            resp_valid = 0;
         end else if (!resp_valid || f_resp) begin
            if (!hold_resp && $urandom_range(99) < p_resp) begin
               resp_valid = 1; resp_data = cfu_resp[0];
            end else begin
               resp_valid = 0;
            end
         end
         res_ready = !hold_res && ($urandom_range(99) < p_res);
      end
   end

   task automatic run_cmd(input int len, input bit fixed, input logic [31:0] fa, input logic [31:0] fw);
      int dot_i;
      int n;
      bit ok;
      logic [31:0] a, w;
      int m;
      exp_pop = '0;
      dot_i = 0;
      for (int i = 0; i < len; i++) begin
         a = fixed ? fa : $urandom;
         w = fixed ? fw : $urandom;
         src_act.push_back(a); src_wt.push_back(w);
         exp_act.push_back(a); exp_wt.push_back(w);
         m = $countones(~(a ^ w));
         exp_pop = exp_pop + 32'(m);
         dot_i = dot_i + m - $countones(a ^ w);
      end
      exp_dot = 32'(dot_i);
      in_cnt = 0;
      req_seen = 0;
      start_hs = res_hs_cnt;
      @(posedge clock);
      #1;
      cmd_valid = 1;
      cmd_len = LEN_W'(len);
      ok = 0;
      n = 0;
      while (!ok && n < 100) begin
         @(negedge clock);
         n++;
         if (cmd_valid && cmd_ready) ok = 1;
      end
      if (!ok) fail("cmd_accept_timeout");
      cmd_cyc = cyc;
      @(posedge clock);
      #1;
      cmd_valid = 0;
   endtask

   task automatic wait_done();
      int n = 0;
      while (res_hs_cnt == start_hs && n < 3000) begin
         @(negedge clock);
         n++;
      end
      if (res_hs_cnt == start_hs) fail("result_timeout");
   endtask

   task automatic check_latency(input int len);
      if (len == 0) check("latency_len0", res_rise_cyc - cmd_cyc, 1);
      else          check("latency", res_rise_cyc - cmd_cyc - 1, len + 3);
   endtask

   task automatic reset_checks();
      check("rst_req_valid", req_valid, 0);
      check("rst_res_valid", res_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_req_data0", req_data0, 0);
      check("rst_req_data1", req_data1, 0);
      check("rst_res_pop", res_pop, 0);
      check("rst_res_dot", res_dot, 0);
      check("rst_resp_ready", resp_ready, 0);
      check("rst_in_ready", in_ready, 0);
   endtask

   task automatic clear_model();
      src_act.delete(); src_wt.delete();
      exp_act.delete(); exp_wt.delete();
      cfu_resp.delete();
      out_cnt = 0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      reset = 1; cmd_valid = 0; cmd_len = '0;
      repeat (3) @(negedge clock);
      reset_checks();
      @(posedge clock);
      #1;
      reset = 0;
      @(negedge clock);
      check("idle_cmd_ready", cmd_ready, 1);

      // single zero word pair, CFU answers 32
      run_cmd(1, 1, 32'h0000_0000, 32'h0000_0000);
      wait_done();
      check("pin_pop_len1", last_pop, 32'd32);
      check("pin_dot_len1", last_dot, 32'd32);
      check_latency(1);

      // all bits mismatch in two words
      run_cmd(2, 1, 32'hFFFF_FFFF, 32'h0000_0000);
      wait_done();
      check("pin_pop_len2", last_pop, 32'd0);
      check("pin_dot_len2", last_dot, 32'hFFFF_FFC0);
      check_latency(2);

      // zero-length command
      run_cmd(0, 0, '0, '0);
      wait_done();
      check("len0_no_request", req_seen, 0);
      check("pin_pop_len0", last_pop, 32'd0);
      check("pin_dot_len0", last_dot, 32'd0);
      check_latency(0);

      // request stall, then outstanding window with the CFU silent
      hold_req = 1; hold_resp = 1;
      run_cmd(8, 0, '0, '0);
      repeat (6) @(negedge clock);
      check("stall_pairs_consumed", in_cnt, 1);
      check("stall_in_ready", in_ready, 0);
      check("stall_req_valid", req_valid, 1);
      hold_req = 0;
      repeat (12) @(negedge clock);
      check("window_full", out_cnt, MAX_OUT);
      check("window_in_ready", in_ready, 0);
      hold_resp = 0;
      wait_done();

      // result held while res_ready is low
      hold_res = 1;
      run_cmd(3, 0, '0, '0);
      n = 0;
      while (!res_valid && n < 500) begin
         @(negedge clock);
         n++;
      end
      if (!res_valid) fail("res_valid_timeout");
      repeat (3) @(negedge clock);
      hold_res = 0;
      wait_done();
      @(negedge clock);
      check("after_done_cmd_ready", cmd_ready, 1);
      check("after_done_busy", busy, 0);

      // reset after one of three words issued
      hold_req = 1;
      run_cmd(3, 0, '0, '0);
      n = 0;
      while (in_cnt < 1 && n < 100) begin
         @(negedge clock);
         n++;
      end
      if (in_cnt < 1) fail("first_word_timeout");
      @(posedge clock);
      #1;
      reset = 1;
      clear_model();
      hold_req = 0;
      @(negedge clock);
      reset_checks();
      @(posedge clock);
      #1;
      reset = 0;
      cfu_resp.push_back(32'd32);
      repeat (3) begin
         @(negedge clock);
         check("stale_resp_ready", resp_ready, 0);
         check("stale_busy", busy, 0);
      end
      cfu_resp.delete();
      @(negedge clock);
      run_cmd(1, 1, 32'h0000_FFFF, 32'h0000_FFFF);
      wait_done();
      check("pin_pop_after_reset", last_pop, 32'd32);
      check("pin_dot_after_reset", last_dot, 32'd32);

      // randomized commands and handshake timing
      for (int t = 0; t < 25; t++) begin
         p_in   = $urandom_range(100, 30);
         p_req  = $urandom_range(100, 30);
         p_resp = $urandom_range(100, 30);
         p_res  = $urandom_range(100, 30);
         run_cmd($urandom_range(12, 0), 0, '0, '0);
         wait_done();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
